// File: rtl/trig_pkg.sv
// Shared definitions for the trigger-ID receiver: FSM encodings and saturating flag counters.
// Records are always packed {timestamp, id}, with the id in the low ID_WIDTH bits.
package trig_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_PUSH  = 2'd2;

    localparam int unsigned SAT_W = 8;

    function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] v);
        return (v == {SAT_W{1'b1}}) ? v : v + SAT_W'(1);
    endfunction

    // A new event beats a simultaneous clear, leaving the counter at 1.
    function automatic logic [SAT_W-1:0] flag_cnt_next(input logic [SAT_W-1:0] v,
                                                        input logic ev,
                                                        input logic clr);
        if (ev)
            return clr ? SAT_W'(1) : sat_inc(v);
        if (clr)
            return '0;
        return v;
    endfunction

endpackage

// File: rtl/trig_id_receiver_if.sv
// MCU-side read/status port of the trigger-ID receiver.
// The receiver uses the master modport, the SPI/MCU side the slave modport.
interface trig_id_receiver_if #(
    parameter int unsigned ID_WIDTH   = 16,
    parameter int unsigned TS_WIDTH   = 16,
    parameter int unsigned FIFO_DEPTH = 16
);
    import trig_pkg::*;

    localparam int unsigned REC_W = TS_WIDTH + ID_WIDTH;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    logic             rd_en;
    logic             clr_flags;
    logic [REC_W-1:0] rd_data;
    logic             rd_valid;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_full;
    logic             fifo_empty;
    logic             irq;
    logic             busy;
    logic             overflow;
    logic [SAT_W-1:0] drop_cnt;
    logic [SAT_W-1:0] timeout_cnt;

    modport master (
        input  rd_en, clr_flags,
        output rd_data, rd_valid, fifo_count, fifo_full, fifo_empty, irq,
               busy, overflow, drop_cnt, timeout_cnt
    );

    modport slave (
        output rd_en, clr_flags,
        input  rd_data, rd_valid, fifo_count, fifo_full, fifo_empty, irq,
               busy, overflow, drop_cnt, timeout_cnt
    );

endinterface

// File: rtl/trig_id_receiver_sync_fifo.sv
// Registered-read dual-pointer FIFO with count/full/empty; a write is accepted
// while full when a pop happens in the same cycle.
module sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 16,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty,
    output logic             nonempty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CNT_W-1:0] count_next;
    logic             do_rd;
    logic             do_wr;

    assign do_rd = rd_en && !empty;
    assign do_wr = wr_en && (!full || do_rd);

    always_comb begin
        count_next = count;
        if (do_wr && !do_rd)
            count_next = count + CNT_W'(1);
        else if (!do_wr && do_rd)
            count_next = count - CNT_W'(1);
    end

    // Small/narrow configurations use a reset-free array so it can sit in one block RAM.
    if (WIDTH <= 16 && DEPTH <= 256) begin : g_ram
        always_ff @(posedge clk) begin
            if (do_wr)
                mem[wr_ptr] <= wr_data;
        end
    end else begin : g_reg
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                mem <= '{default: '0};
            else if (do_wr)
                mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            nonempty <= 1'b0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            count    <= count_next;
            full     <= (count_next == CNT_W'(DEPTH));
            empty    <= (count_next == '0);
            nonempty <= (count_next != '0);
            rd_valid <= do_rd;
            if (do_wr)
                wr_ptr <= wr_ptr + AW'(1);
            if (do_rd) begin
                rd_ptr  <= rd_ptr + AW'(1);
                rd_data <= mem[rd_ptr];
            end
        end
    end

endmodule

// File: rtl/trig_id_receiver.sv
// Trigger-ID capture: synchronises trigger/serial-ID pins, timestamps each trigger,
// shifts in the serial ID under a timeout guard and queues {ts, id} records.
module trig_id_receiver
    import trig_pkg::*;
#(
    parameter int unsigned ID_WIDTH    = 16,
    parameter int unsigned TS_WIDTH    = 16,
    parameter int unsigned FIFO_DEPTH  = 16,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned TIMEOUT     = 1023,
    parameter bit          MSB_FIRST   = 1'b1
) (
    input  logic               pll_clk,
    input  logic               reset,
    input  logic               trig_in,
    input  logic               trig_id,
    input  logic               id_clk,
    trig_id_receiver_if.master bus
);

    localparam int unsigned REC_W = TS_WIDTH + ID_WIDTH;
    localparam int unsigned BIT_W = $clog2(ID_WIDTH + 1);
    localparam int unsigned TO_W  = $clog2(TIMEOUT + 1);

    // Synchroniser chain, bit order {trig_in, trig_id, id_clk}; equal depth keeps data aligned to clock.
    for (genvar i = 0; i < SYNC_STAGES; i++) begin : g_sync
        logic [2:0] q;
        if (i == 0) begin : g_first
            always_ff @(posedge pll_clk or negedge reset) begin
                if (!reset) q <= '0;
                else        q <= {trig_in, trig_id, id_clk};
            end
        end else begin : g_next
            always_ff @(posedge pll_clk or negedge reset) begin
                if (!reset) q <= '0;
                else        q <= g_sync[i-1].q;
            end
        end
    end

    logic [2:0] sync_s;
    logic       trig_d;
    logic       clk_d;
    logic       trig_rise;
    logic       clk_fall;
    logic       bit_in;

    assign sync_s    = g_sync[SYNC_STAGES-1].q;
    assign trig_rise = sync_s[2] && !trig_d;
    assign clk_fall  = !sync_s[0] && clk_d;
    assign bit_in    = sync_s[1];

    always_ff @(posedge pll_clk or negedge reset) begin
        if (!reset) begin
            trig_d <= 1'b0;
            clk_d  <= 1'b0;
        end else begin
            trig_d <= sync_s[2];
            clk_d  <= sync_s[0];
        end
    end

    logic [1:0]          state;
    logic [1:0]          state_next;
    logic                start_c;
    logic                shift_c;
    logic                abort_c;
    logic                push_c;
    logic                drop_c;
    logic [TS_WIDTH-1:0] ts_cnt;
    logic [TS_WIDTH-1:0] ts_lat;
    logic [ID_WIDTH-1:0] sr;
    logic [BIT_W-1:0]    bit_cnt;
    logic [TO_W-1:0]     to_cnt;

    always_ff @(posedge pll_clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        start_c    = 1'b0;
        shift_c    = 1'b0;
        abort_c    = 1'b0;
        push_c     = 1'b0;
        drop_c     = trig_rise && (state != ST_IDLE);
        case (state)
            ST_IDLE: begin
                if (trig_rise) begin
                    start_c    = 1'b1;
                    state_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (clk_fall) begin
                    shift_c = 1'b1;
                    if (bit_cnt == BIT_W'(ID_WIDTH - 1))
                        state_next = ST_PUSH;
                end else if (to_cnt == TO_W'(TIMEOUT)) begin
                    abort_c    = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            ST_PUSH: begin
                push_c     = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Timestamp, shift register, bit and timeout counters.
    always_ff @(posedge pll_clk or negedge reset) begin
        if (!reset) begin
            ts_cnt  <= '0;
            ts_lat  <= '0;
            sr      <= '0;
            bit_cnt <= '0;
            to_cnt  <= '0;
        end else begin
            ts_cnt <= ts_cnt + TS_WIDTH'(1);
            if (start_c) begin
                ts_lat  <= ts_cnt;
                sr      <= '0;
                bit_cnt <= '0;
                to_cnt  <= '0;
            end else if (shift_c) begin
                if (MSB_FIRST)
                    sr <= (sr << 1) | ID_WIDTH'(bit_in);
                else
                    sr <= (sr >> 1) | (ID_WIDTH'(bit_in) << (ID_WIDTH - 1));
                bit_cnt <= bit_cnt + BIT_W'(1);
                to_cnt  <= '0;
            end else if (state == ST_SHIFT && !abort_c) begin
                to_cnt <= to_cnt + TO_W'(1);
            end
        end
    end

    sync_fifo #(
        .WIDTH (REC_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (pll_clk),
        .rst_n    (reset),
        .wr_en    (push_c),
        .wr_data  ({ts_lat, sr}),
        .rd_en    (bus.rd_en),
        .rd_data  (bus.rd_data),
        .rd_valid (bus.rd_valid),
        .count    (bus.fifo_count),
        .full     (bus.fifo_full),
        .empty    (bus.fifo_empty),
        .nonempty (bus.irq)
    );

    // Status flags; a record is lost only when full with no pop in the PUSH cycle.
    always_ff @(posedge pll_clk or negedge reset) begin
        if (!reset) begin
            bus.busy        <= 1'b0;
            bus.overflow    <= 1'b0;
            bus.drop_cnt    <= '0;
            bus.timeout_cnt <= '0;
        end else begin
            bus.busy <= (state_next != ST_IDLE);
            if (push_c && bus.fifo_full && !bus.rd_en)
                bus.overflow <= 1'b1;
            else if (bus.clr_flags)
                bus.overflow <= 1'b0;
            bus.drop_cnt    <= flag_cnt_next(bus.drop_cnt, drop_c, bus.clr_flags);
            bus.timeout_cnt <= flag_cnt_next(bus.timeout_cnt, abort_c, bus.clr_flags);
        end
    end

endmodule

// File: tb/tb_trig_id_receiver.sv
// Directed bench: MSB-first 16-bit instance (a) and LSB-first 8-bit/8-bit-timestamp instance (b).
module tb_trig_id_receiver;
    import trig_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic trig, tid, idck, sel;
    logic trig_a, tid_a, idck_a, trig_b, tid_b, idck_b;
    assign trig_a = sel ? 1'b0 : trig;
    assign tid_a  = sel ? 1'b0 : tid;
    assign idck_a = sel ? 1'b0 : idck;
    assign trig_b = sel ? trig : 1'b0;
    assign tid_b  = sel ? tid  : 1'b0;
    assign idck_b = sel ? idck : 1'b0;

    trig_id_receiver_if #(.ID_WIDTH(16), .TS_WIDTH(16), .FIFO_DEPTH(16)) bus_a ();
    trig_id_receiver_if #(.ID_WIDTH(8),  .TS_WIDTH(8),  .FIFO_DEPTH(4))  bus_b ();

    trig_id_receiver #(
        .ID_WIDTH(16), .TS_WIDTH(16), .FIFO_DEPTH(16),
        .SYNC_STAGES(2), .TIMEOUT(1023), .MSB_FIRST(1'b1)
    ) dut_a (
        .pll_clk(clk), .reset(rst_n), .trig_in(trig_a), .trig_id(tid_a),
        .id_clk(idck_a), .bus(bus_a)
    );

    trig_id_receiver #(
        .ID_WIDTH(8), .TS_WIDTH(8), .FIFO_DEPTH(4),
        .SYNC_STAGES(2), .TIMEOUT(1023), .MSB_FIRST(1'b0)
    ) dut_b (
        .pll_clk(clk), .reset(rst_n), .trig_in(trig_b), .trig_id(tid_b),
        .id_clk(idck_b), .bus(bus_b)
    );

    // Reference time base: cycles since reset release.
    logic [15:0] ref_ts;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) ref_ts <= 16'd0;
        else        ref_ts <= ref_ts + 16'd1;
    end

    int checks = 0;
    int passes = 0;
    logic [31:0] exp_q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) passes++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Sends v[n-1] first; data changes on id_clk rise, 4 cycles high + 4 low.
    task automatic send_bits(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            tid  = v[i];
            idck = 1'b1;
            cyc(4);
            idck = 1'b0;
            cyc(4);
        end
    endtask

    // Trigger rises now; detection happens two edges later (2 sync stages).
    task automatic start_trig(output logic [15:0] ets);
        trig = 1'b1;
        ets  = ref_ts + 16'd2;
        cyc(2);
    endtask

    task automatic capture(input logic [15:0] id, output logic [15:0] ets);
        start_trig(ets);
        send_bits({16'd0, id}, 16);
        trig = 1'b0;
        cyc(8);
    endtask

    task automatic pop_a(output logic [31:0] d, output logic v);
        bus_a.rd_en = 1'b1;
        cyc(1);
        bus_a.rd_en = 1'b0;
        d = bus_a.rd_data;
        v = bus_a.rd_valid;
    endtask

    task automatic pop_b(output logic [15:0] d, output logic v);
        bus_b.rd_en = 1'b1;
        cyc(1);
        bus_b.rd_en = 1'b0;
        d = bus_b.rd_data;
        v = bus_b.rd_valid;
    endtask

    task automatic chk_reset_a(input string tag);
        chk({tag, "_rd_data"},  64'(bus_a.rd_data),     64'h0);
        chk({tag, "_rd_valid"}, 64'(bus_a.rd_valid),    64'h0);
        chk({tag, "_count"},    64'(bus_a.fifo_count),  64'h0);
        chk({tag, "_full"},     64'(bus_a.fifo_full),   64'h0);
        chk({tag, "_empty"},    64'(bus_a.fifo_empty),  64'h1);
        chk({tag, "_irq"},      64'(bus_a.irq),         64'h0);
        chk({tag, "_busy"},     64'(bus_a.busy),        64'h0);
        chk({tag, "_overflow"}, 64'(bus_a.overflow),    64'h0);
        chk({tag, "_drop"},     64'(bus_a.drop_cnt),    64'h0);
        chk({tag, "_timeout"},  64'(bus_a.timeout_cnt), 64'h0);
    endtask

    initial begin
        #2_000_000;
        checks++;
        $display("FAIL watchdog: observed no finish, expected finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] ets;
        logic [31:0] d;
        logic [15:0] db;
        logic        v;

        sel = 1'b0; trig = 1'b0; tid = 1'b0; idck = 1'b0;
        bus_a.rd_en = 1'b0; bus_a.clr_flags = 1'b0;
        bus_b.rd_en = 1'b0; bus_b.clr_flags = 1'b0;
        cyc(3);
        chk_reset_a("rst");
        chk("rst_b_empty", 64'(bus_b.fifo_empty), 64'h1);
        rst_n = 1'b1;
        cyc(4);

        // Basic MSB-first capture of 0xA5C3.
        start_trig(ets);
        send_bits(32'hA5, 8);
        chk("basic_busy_mid", 64'(bus_a.busy), 64'h1);
        send_bits(32'hC3, 8);
        trig = 1'b0;
        cyc(8);
        chk("basic_count", 64'(bus_a.fifo_count), 64'h1);
        chk("basic_irq",   64'(bus_a.irq),        64'h1);
        chk("basic_empty", 64'(bus_a.fifo_empty), 64'h0);
        chk("basic_busy",  64'(bus_a.busy),       64'h0);
        pop_a(d, v);
        chk("basic_rd_valid", 64'(v), 64'h1);
        chk("basic_rd_data",  64'(d), 64'({ets, 16'hA5C3}));
        chk("basic_empty_after", 64'(bus_a.fifo_empty), 64'h1);
        chk("basic_irq_after",   64'(bus_a.irq),        64'h0);
        cyc(1);
        chk("basic_valid_strobe", 64'(bus_a.rd_valid), 64'h0);
        pop_a(d, v);
        chk("empty_read_valid", 64'(v), 64'h0);
        chk("empty_read_count", 64'(bus_a.fifo_count), 64'h0);

        // Timeout after 5 bits, then a normal capture.
        start_trig(ets);
        send_bits(32'h16, 5);
        trig = 1'b0;
        cyc(1100);
        chk("to_cnt",   64'(bus_a.timeout_cnt), 64'h1);
        chk("to_count", 64'(bus_a.fifo_count),  64'h0);
        chk("to_busy",  64'(bus_a.busy),        64'h0);
        capture(16'h1234, ets);
        pop_a(d, v);
        chk("to_next_valid", 64'(v), 64'h1);
        chk("to_next_data",  64'(d), 64'({ets, 16'h1234}));

        // Retrigger mid-shift.
        start_trig(ets);
        send_bits(32'hBE, 8);
        trig = 1'b0;
        cyc(4);
        trig = 1'b1;
        cyc(2);
        send_bits(32'hEF, 8);
        trig = 1'b0;
        cyc(8);
        chk("retrig_drop",  64'(bus_a.drop_cnt),   64'h1);
        chk("retrig_count", 64'(bus_a.fifo_count), 64'h1);
        pop_a(d, v);
        chk("retrig_data", 64'(d), 64'({ets, 16'hBEEF}));

        // Fill to 16, then overflow with rd_en low.
        for (int i = 0; i < 16; i++) begin
            capture(16'h0100 + 16'(i), ets);
            exp_q.push_back({ets, 16'h0100 + 16'(i)});
        end
        chk("fill_count", 64'(bus_a.fifo_count), 64'd16);
        chk("fill_full",  64'(bus_a.fifo_full),  64'h1);
        chk("fill_ovf",   64'(bus_a.overflow),   64'h0);
        capture(16'hDEAD, ets);
        chk("ovf_flag",  64'(bus_a.overflow),   64'h1);
        chk("ovf_count", 64'(bus_a.fifo_count), 64'd16);
        bus_a.clr_flags = 1'b1;
        cyc(1);
        bus_a.clr_flags = 1'b0;
        chk("clr_ovf",     64'(bus_a.overflow),    64'h0);
        chk("clr_drop",    64'(bus_a.drop_cnt),    64'h0);
        chk("clr_timeout", 64'(bus_a.timeout_cnt), 64'h0);

        // Full with rd_en exactly in the PUSH cycle: record kept.
        start_trig(ets);
        send_bits(32'h0B0B >> 1, 15);
        tid  = 1'b1;
        idck = 1'b1;
        cyc(4);
        idck = 1'b0;
        cyc(3);
        chk("push_busy", 64'(bus_a.busy), 64'h1);
        bus_a.rd_en = 1'b1;
        cyc(1);
        bus_a.rd_en = 1'b0;
        chk("fullrw_valid", 64'(bus_a.rd_valid),   64'h1);
        chk("fullrw_data",  64'(bus_a.rd_data),    64'(exp_q.pop_front()));
        chk("fullrw_count", 64'(bus_a.fifo_count), 64'd16);
        chk("fullrw_ovf",   64'(bus_a.overflow),   64'h0);
        exp_q.push_back({ets, 16'h0B0B});
        trig = 1'b0;
        cyc(4);
        for (int i = 0; i < 16; i++) begin
            pop_a(d, v);
            chk("drain_valid", 64'(v), 64'h1);
            chk("drain_data",  64'(d), 64'(exp_q.pop_front()));
        end
        chk("drain_empty", 64'(bus_a.fifo_empty), 64'h1);

        // LSB-first instance: bits 1,0,0,0,0,0,0,0 -> 0x01.
        sel = 1'b1;
        cyc(2);
        start_trig(ets);
        send_bits(32'h80, 8);
        trig = 1'b0;
        cyc(8);
        chk("lsb_count", 64'(bus_b.fifo_count), 64'h1);
        pop_b(db, v);
        chk("lsb_valid", 64'(v),  64'h1);
        chk("lsb_data",  64'(db), 64'({ets[7:0], 8'h01}));
        // Trigger detected as the 8-bit counter wraps to 0; bits 0,0,0,0,0,0,1,1 -> 0xC0.
        for (int k = 0; k < 300 && ref_ts[7:0] != 8'd254; k++)
            cyc(1);
        start_trig(ets);
        send_bits(32'h03, 8);
        trig = 1'b0;
        cyc(8);
        pop_b(db, v);
        chk("wrap_valid", 64'(v),  64'h1);
        chk("wrap_data",  64'(db), 64'h00C0);
        sel = 1'b0;
        cyc(2);

        // Reset mid-shift with three records queued.
        for (int i = 0; i < 3; i++)
            capture(16'h0001 + 16'(i), ets);
        chk("pre_rst_count", 64'(bus_a.fifo_count), 64'd3);
        start_trig(ets);
        send_bits(32'h15, 5);
        rst_n = 1'b0;
        cyc(1);
        chk_reset_a("midrst");
        trig = 1'b0;
        cyc(1);
        rst_n = 1'b1;
        cyc(3);
        chk("post_rst_count", 64'(bus_a.fifo_count), 64'h0);
        chk("post_rst_busy",  64'(bus_a.busy),       64'h0);
        capture(16'h5A5A, ets);
        chk("post_rst_cap_count", 64'(bus_a.fifo_count), 64'h1);
        pop_a(d, v);
        chk("post_rst_data", 64'(d), 64'({ets, 16'h5A5A}));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
